// File: rtl/fpu_sequencer.sv
// Control sequencer for a floating-point add/sub/mul datapath.
// Walks each operation through unpack, exponent alignment (add/sub only),
// the mantissa operation, normalization, rounding and register write-back.
// Every output is decoded from the current state and the shift counter.
// The two shift enables also look at the matching datapath status input.
module fpu_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       Start,
  input  logic [1:0] FPOp,
  input  logic       Flush,
  input  logic       Special,
  input  logic       AlignDone,
  input  logic       NormDone,
  output logic       LoadOperands,
  output logic       AlignShiftEn,
  output logic       NormShiftEn,
  output logic       RoundEn,
  output logic [1:0] MantOp,
  output logic       FPUWrite,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_MUL,
    S_NORM,
    S_ROUND,
    S_WRITE
  } state_t;

  localparam logic [1:0] OP_ADD      = 2'b00;
  localparam logic [1:0] OP_MUL      = 2'b10;
  localparam logic [1:0] OP_RESERVED = 2'b11;

  localparam logic [1:0] MANT_HOLD = 2'b00;
  localparam logic [1:0] MANT_ADD  = 2'b01;
  localparam logic [1:0] MANT_SUB  = 2'b10;
  localparam logic [1:0] MANT_MUL  = 2'b11;

  // A phase may shift at most 24 times. The phase is left on the cycle whose
  // increment brings the count to 24, so saturation gives exactly 24 shift
  // cycles and the mantissa op follows immediately.
  localparam logic [4:0] SHIFT_LIMIT = 5'd24;
  localparam logic [4:0] SHIFT_LAST  = 5'd23;
  localparam logic [4:0] MUL_LAST    = 5'd3;

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [4:0] cnt_q, cnt_d;

  // State, latched operation and shift counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The operation register is loaded only on acceptance in IDLE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (Start && (FPOp != OP_RESERVED)) begin
          op_d    = FPOp;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        if (Special)              state_d = S_WRITE;
        else if (op_q == OP_MUL)  state_d = S_MUL;
        else                      state_d = S_ALIGN;
      end
      S_ALIGN: begin
        if (AlignDone || (cnt_q == SHIFT_LAST)) state_d = S_ADD;
      end
      S_ADD:   state_d = S_NORM;
      S_MUL: begin
        if (cnt_q == MUL_LAST) state_d = S_NORM;
      end
      S_NORM: begin
        if (NormDone || (cnt_q == SHIFT_LAST)) state_d = S_ROUND;
      end
      S_ROUND: state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything, including a Start seen in the same cycle.
    if (Flush) begin
      state_d = S_IDLE;
      op_d    = op_q;
    end
  end

  // Shift counter: cleared on any state change, counts cycles inside the timed phases.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = 5'd0;
    end else if ((state_q == S_ALIGN) || (state_q == S_MUL) || (state_q == S_NORM)) begin
      cnt_d = cnt_q + 5'd1;
    end
  end

  // Output decode from state and counter; IDLE (and therefore reset) drives all zeros.
  always_comb begin
    LoadOperands = 1'b0;
    AlignShiftEn = 1'b0;
    NormShiftEn  = 1'b0;
    RoundEn      = 1'b0;
    MantOp       = MANT_HOLD;
    FPUWrite     = 1'b0;
    Busy         = (state_q != S_IDLE);
    Done         = 1'b0;
    case (state_q)
      S_UNPACK: LoadOperands = 1'b1;
      S_ALIGN:  AlignShiftEn = !AlignDone && (cnt_q < SHIFT_LIMIT);
      S_ADD:    MantOp = (op_q == OP_ADD) ? MANT_ADD : MANT_SUB;
      S_MUL:    MantOp = MANT_MUL;
      S_NORM:   NormShiftEn = !NormDone && (cnt_q < SHIFT_LIMIT);
      S_ROUND:  RoundEn = 1'b1;
      S_WRITE: begin
        FPUWrite = 1'b1;
        Done     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Self-checking bench for fpu_sequencer. A timeline model builds the expected
// cycle-by-cycle output pattern of each operation from its phase lengths.
// It also supplies the status inputs to drive on each cycle.
module tb_fpu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       Start;
  logic [1:0] FPOp;
  logic       Flush;
  logic       Special;
  logic       AlignDone;
  logic       NormDone;
  logic       LoadOperands;
  logic       AlignShiftEn;
  logic       NormShiftEn;
  logic       RoundEn;
  logic [1:0] MantOp;
  logic       FPUWrite;
  logic       Busy;
  logic       Done;

  int checks   = 0;
  int failures = 0;

  fpu_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .Start       (Start),
    .FPOp        (FPOp),
    .Flush       (Flush),
    .Special     (Special),
    .AlignDone   (AlignDone),
    .NormDone    (NormDone),
    .LoadOperands(LoadOperands),
    .AlignShiftEn(AlignShiftEn),
    .NormShiftEn (NormShiftEn),
    .RoundEn     (RoundEn),
    .MantOp      (MantOp),
    .FPUWrite    (FPUWrite),
    .Busy        (Busy),
    .Done        (Done)
  );

  always #5 clk = ~clk;

  // {LoadOperands, AlignShiftEn, NormShiftEn, RoundEn, MantOp, FPUWrite, Busy, Done}
  wire [8:0] out_vec = {LoadOperands, AlignShiftEn, NormShiftEn, RoundEn,
                        MantOp, FPUWrite, Busy, Done};

  typedef struct {
    logic [8:0] exp;
    bit         sp;
    bit         ad;
    bit         nd;
  } cyc_t;

  cyc_t exp_q[$];

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic void push(bit ld, bit as, bit ns, bit re, logic [1:0] mo,
                               bit fw, bit bs, bit dn, bit sp, bit ad, bit nd);
    cyc_t c;
    c.exp = {ld, as, ns, re, mo, fw, bs, dn};
    c.sp  = sp;
    c.ad  = ad;
    c.nd  = nd;
    exp_q.push_back(c);
  endfunction

  // Expected timeline after Start is accepted. Entry 0 is the cycle after Start.
  // a and n are the number of cycles AlignDone / NormDone stay low.
  function automatic void build(logic [1:0] op, bit sp, int a, int n);
    int len;
    exp_q.delete();
    push(1, 0, 0, 0, 2'b00, 0, 1, 0, sp, rb(), rb());             // unpack
    if (sp) begin
      push(0, 0, 0, 0, 2'b00, 1, 1, 1, rb(), rb(), rb());         // write
    end else begin
      if (op == 2'b10) begin
        for (int k = 0; k < 4; k++) push(0, 0, 0, 0, 2'b11, 0, 1, 0, rb(), rb(), rb());
      end else begin
        len = (a >= 24) ? 24 : a + 1;
        for (int k = 0; k < len; k++)
          push(0, k < a, 0, 0, 2'b00, 0, 1, 0, rb(), k >= a, rb());
        push(0, 0, 0, 0, (op == 2'b00) ? 2'b01 : 2'b10, 0, 1, 0, rb(), rb(), rb());
      end
      len = (n >= 24) ? 24 : n + 1;
      for (int k = 0; k < len; k++)
        push(0, 0, k < n, 0, 2'b00, 0, 1, 0, rb(), rb(), k >= n);
      push(0, 0, 0, 1, 2'b00, 0, 1, 0, rb(), rb(), rb());         // round
      push(0, 0, 0, 0, 2'b00, 1, 1, 1, rb(), rb(), rb());         // write
    end
    push(0, 0, 0, 0, 2'b00, 0, 0, 0, rb(), rb(), rb());           // back in idle
  endfunction

  // Issue one operation and compare up to 'limit' cycles of its timeline.
  // With spam set, Start pulses with random FPOp while the operation runs.
  task automatic run_op(input logic [1:0] op, input bit sp, input int a, input int n,
                        input bit spam, input int limit, input string tag);
    build(op, sp, a, n);
    @(posedge clk); #1;
    Start = 1'b1;
    FPOp  = op;
    for (int i = 0; i < exp_q.size() && i < limit; i++) begin
      @(posedge clk); #1;
      Start     = (spam && (i != exp_q.size() - 1)) ? rb() : 1'b0;
      FPOp      = 2'($urandom_range(0, 3));
      Special   = exp_q[i].sp;
      AlignDone = exp_q[i].ad;
      NormDone  = exp_q[i].nd;
      @(negedge clk);
      checks++;
      if (out_vec !== exp_q[i].exp) begin
        failures++;
        $display("FAIL %s op=%0d a=%0d n=%0d cycle c%0d: outputs got %b expected %b",
                 tag, op, a, n, i + 1, out_vec, exp_q[i].exp);
      end
    end
    Start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      Start = rb(); FPOp = 2'($urandom_range(0, 2));
      Special = rb(); AlignDone = rb(); NormDone = rb();
      @(negedge clk);
      checks++;
      if (out_vec !== 9'b0) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: got %b expected %b", i, out_vec, 9'b0);
      end
    end
    Start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_add_fast();
    run_op(2'b00, 0, 0, 0, 0, 1000, "add_fast");
  endtask

  task automatic test_mul();
    run_op(2'b10, 0, 0, 0, 0, 1000, "mul");
    run_op(2'b10, 0, 0, 5, 0, 1000, "mul_norm_wait");
  endtask

  task automatic test_saturation();
    run_op(2'b01, 0, 40, 0, 0, 1000, "align_sat");
    run_op(2'b00, 0, 23, 24, 0, 1000, "align23_norm_sat");
    run_op(2'b10, 0, 0, 31, 0, 1000, "mul_norm_sat");
  endtask

  task automatic test_special_reserved();
    run_op(2'b00, 1, 0, 0, 0, 1000, "special_add");
    run_op(2'b10, 1, 0, 0, 0, 1000, "special_mul");
    @(posedge clk); #1;
    Start = 1'b1; FPOp = 2'b11;
    @(posedge clk); #1;
    Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_vec !== 9'b0) begin
        failures++;
        $display("FAIL reserved_op cycle %0d: got %b expected %b", i, out_vec, 9'b0);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    // Flush during the second MUL cycle (c3): idle at c4, nothing written afterwards.
    run_op(2'b10, 0, 0, 0, 0, 2, "flush_pre");
    @(posedge clk); #1;
    Flush = 1'b1;
    @(negedge clk);
    checks++;
    if (out_vec !== 9'b000011010) begin
      failures++;
      $display("FAIL flush_c3_mul: got %b expected %b", out_vec, 9'b000011010);
    end
    @(posedge clk); #1;
    Flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_vec !== 9'b0) begin
        failures++;
        $display("FAIL flush_idle cycle c%0d: got %b expected %b", i + 4, out_vec, 9'b0);
      end
      @(posedge clk); #1;
    end
    // Flush together with Start in IDLE: the request is dropped.
    Start = 1'b1; FPOp = 2'b00; Flush = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; Flush = 1'b0;
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_over_start: Busy got %b expected 0", Busy);
    end
    // A normal add still completes after the flushes.
    run_op(2'b00, 0, 2, 1, 0, 1000, "after_flush");
  endtask

  task automatic test_reset_mid();
    // Reach the first NORM cycle (c4) of an add, then reset mid-cycle.
    run_op(2'b00, 0, 0, 10, 0, 4, "reset_pre");
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_vec !== 9'b0) begin
      failures++;
      $display("FAIL reset_async_outputs: got %b expected %b", out_vec, 9'b0);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_op(2'b00, 0, 0, 0, 0, 1000, "add_after_reset");
  endtask

  task automatic test_busy_ignore();
    run_op(2'b01, 0, 3, 2, 1, 1000, "busy_ignore_sub");
    run_op(2'b10, 0, 0, 4, 1, 1000, "busy_ignore_mul");
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      run_op(2'($urandom_range(0, 2)), ($urandom_range(0, 9) == 0),
             int'($urandom_range(0, 27)), int'($urandom_range(0, 27)),
             rb(), 1000, "random");
    end
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; FPOp = 2'b00; Flush = 1'b0;
    Special = 1'b0; AlignDone = 1'b0; NormDone = 1'b0;
    test_reset();
    test_add_fast();
    test_mul();
    test_saturation();
    test_special_reserved();
    test_flush();
    test_reset_mid();
    test_busy_ignore();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_sequencer.md
FPU_SEQUENCER -- requirements
Module: fpu_sequencer

Interface
REQ-001 SHALL have ports clk (in, 1, system clock) and reset (in, 1, asynchronous active-high reset).
REQ-002 SHALL have Start (in, 1): one-cycle request from the core controller to begin an FP operation.
REQ-003 SHALL have FPOp (in, 2): operation, where 00 = add, 01 = sub, 10 = mul, 11 = reserved.
REQ-004 SHALL have Flush (in, 1): synchronous abort of the operation in flight.
REQ-005 SHALL have Special (in, 1), AlignDone (in, 1) and NormDone (in, 1) as datapath status inputs. Special flags a NaN, Inf or zero operand. AlignDone means the exponents are equal. NormDone means the mantissa is normalized or zero.
REQ-006 SHALL have LoadOperands, AlignShiftEn, NormShiftEn and RoundEn (out, 1 each) as datapath enables.
REQ-007 SHALL have MantOp (out, 2): mantissa unit control, where 00 = hold, 01 = add, 10 = sub, 11 = mul.
REQ-008 SHALL have FPUWrite (out, 1, FP register file write enable), Busy (out, 1) and Done (out, 1).

Function
REQ-009 SHALL implement a Moore FSM with states IDLE, UNPACK, ALIGN, ADD, MUL, NORM, ROUND and WRITE; all outputs SHALL be decoded from state and counter only.
REQ-010 In IDLE, Start=1 with FPOp != 11 SHALL latch FPOp into OpReg and enter UNPACK next cycle. Start with FPOp=11 SHALL be ignored.
REQ-011 Start SHALL be ignored in every state other than IDLE; OpReg SHALL NOT change outside IDLE.
REQ-012 UNPACK SHALL last 1 cycle with LoadOperands=1. Next state: WRITE if Special=1; else MUL if OpReg=10; else ALIGN.
REQ-013 A 5-bit ShiftCnt SHALL clear to 0 on entry to ALIGN, MUL and NORM, and SHALL increment once per cycle spent in those states.
REQ-014 ALIGN SHALL assert AlignShiftEn = !AlignDone && ShiftCnt<24. It SHALL go to ADD when AlignDone=1 or ShiftCnt=24. ALIGN SHALL occupy at least 1 cycle.
REQ-015 ADD SHALL last 1 cycle with MantOp=01 (OpReg=00) or MantOp=10 (OpReg=01), then go to NORM.
REQ-016 MUL SHALL hold MantOp=11 for exactly 4 cycles (ShiftCnt 0..3), then go to NORM.
REQ-017 NORM SHALL assert NormShiftEn = !NormDone && ShiftCnt<24. It SHALL go to ROUND when NormDone=1 or ShiftCnt=24. NORM SHALL occupy at least 1 cycle.
REQ-018 ROUND SHALL last 1 cycle with RoundEn=1, then go to WRITE.
REQ-019 WRITE SHALL last 1 cycle with FPUWrite=1 and Done=1, then go to IDLE. FPUWrite SHALL be asserted in no other state.
REQ-020 Busy SHALL be 1 in every state except IDLE. MantOp SHALL be 00 outside ADD and MUL.
REQ-021 Flush=1 in any state SHALL force IDLE on the next edge, with no FPUWrite for the aborted operation. Flush SHALL override Start in the same cycle.
REQ-022 Minimum latency from Start to FPUWrite SHALL be: add/sub 6 cycles, mul 8 cycles, special-operand 2 cycles. Each ALIGN or NORM wait cycle beyond the first SHALL add 1 cycle, with at most 23 extra per phase.

Reset
REQ-023 On reset=1, asynchronously and independent of clk: state SHALL become IDLE, and OpReg and ShiftCnt SHALL clear to 0.
REQ-024 While in reset all outputs SHALL be 0: LoadOperands, AlignShiftEn, NormShiftEn, RoundEn, FPUWrite, Busy, Done = 0 and MantOp = 00.
REQ-025 Reset asserted mid-operation SHALL discard the operation, with no FPUWrite. The first Start after reset deasserts SHALL be accepted normally.

Verification
REQ-026 Add fast path: Start with FPOp=00, AlignDone=1, NormDone=1, Special=0 at cycle 0 -> required response:
- LoadOperands at c1
- MantOp=01 at c3
- RoundEn at c5
- FPUWrite=Done=1 at c6
- Busy=0 at c7
REQ-027 Mul: Start with FPOp=10 -> MantOp=11 for exactly c2-c5, FPUWrite at c8, AlignShiftEn never asserted.
REQ-028 Align saturation: FPOp=01 with AlignDone held 0 -> required response:
- AlignShiftEn high for exactly 24 cycles
- then MantOp=10 for 1 cycle
- then NORM follows
REQ-029 Special and reserved: Special=1 in UNPACK -> FPUWrite at c2. Start with FPOp=11 -> Busy stays 0.
REQ-030 Abort: Flush in MUL at c3 -> IDLE at c4 with no FPUWrite. Reset asserted in NORM -> all outputs 0 immediately, then a new add completes in 6 cycles.
REQ-031 Busy ignore: Start pulses every cycle during an operation -> exactly one FPUWrite, and OpReg unchanged.
